pulse_period_meter: RTL and testbench
=====================================

# pulse_period_meter

Measures the interval, in `clk_in` cycles, between successive rising edges of a tick/pulse stream, such as the sample-rate tick of the DDS timer. It is the receive side of that tick interface. It recovers the period the generator used, flags when the period is stable (lock), and reports overflow when pulses stop. It sits beside the DDS core as a self-check/monitor and as a frequency-measurement input for external tick sources.

## Interface
- `WIDTH`, default 24: width of the period counter and result.
- `SYNC_STAGES`, default 2: synchronizer flops on `pulse_in`; minimum 1.
- `MAX_PERIOD`, default 2^WIDTH-1: saturation/overflow threshold in cycles; the bench reduces it.
- `LOCK_COUNT`, default 4: consecutive identical periods required to assert lock; range 1..15.
- `clk_in`, input, 1: system clock.
- `rst_in`, input, 1: reset, asynchronous, active-low.
- `en_in`, input, 1: measurement enable, synchronous.
- `pulse_in`, input, 1: pulse stream; may be asynchronous; any high width.
- `period_out`, output, WIDTH: last measured period in cycles; holds until the next measurement.
- `period_valid_out`, output, 1: one-cycle strobe when `period_out` updates.
- `locked_out`, output, 1: period stable for LOCK_COUNT consecutive measurements.
- `overflow_out`, output, 1: no edge within MAX_PERIOD cycles; sticky until the next edge.

## Operation
- **Front end:** `pulse_in` passes through a SYNC_STAGES flop chain, then a one-flop delay. `edge` = synced & ~delayed. A high level lasting N cycles produces exactly one edge.
- **Cycle counter `cnt`:**
  - Loads 1 on `edge`.
  - Otherwise increments, saturating at MAX_PERIOD.
- **FSM states:**
  - IDLE: waiting for first edge; `cnt` held at 0.
  - MEASURE: counting between edges.
  - OVERFLOW: counter saturated.
- **Transitions:**
  - IDLE + edge: go to MEASURE, `cnt`<=1, no valid.
  - MEASURE + edge: `period_out`<=`cnt`, `period_valid_out`<=1, `cnt`<=1, stay in MEASURE.
  - MEASURE + `cnt`==MAX_PERIOD without edge: go to OVERFLOW, `overflow_out`<=1, `locked_out`<=0, match count cleared.
  - OVERFLOW + edge: go to MEASURE, `overflow_out`<=0, `cnt`<=1. No valid strobe, because the interval is unknown.
  - Any state + `en_in`=0: go to IDLE. `cnt`, match count, `locked_out` and `overflow_out` clear. `period_out` holds.
- **Resulting period:** edges at cycles t0 and t0+P report `period_out`=P. The minimum reportable period is 2, since the input must be sampled low at least once between edges.
- **Lock logic (on each valid measurement):**
  - New period equal to previous `period_out`: match count increments, saturating at LOCK_COUNT.
  - Otherwise: match count = 1.
  - `locked_out` = (match count >= LOCK_COUNT), registered with the same update as `period_valid_out`.
  - A mismatching measurement drops `locked_out` in the same cycle the strobe asserts.
- **Simultaneous events:**
  - `edge` in the same cycle `cnt` reaches MAX_PERIOD: the edge wins, reports MAX_PERIOD as valid, no overflow.
  - `en_in`=0 in the same cycle as `edge`: the disable wins.

## Timing
- **Reset values:** `period_out`=0, `period_valid_out`=0, `locked_out`=0, `overflow_out`=0; FSM in IDLE; `cnt`=0; synchronizer flops=0.
- **Latency:** `pulse_in` first sampled high at clock edge k gives `period_valid_out` high in the cycle after edge k+SYNC_STAGES+1. With the default, valid goes high 3 edges after first sampling.
- **Strobe width:** `period_valid_out` is exactly one cycle; it never asserts on two consecutive cycles.
- **Outputs:** `locked_out` and `overflow_out` are registered with no combinational path from inputs.
- **Reset mid-measurement:** immediate return to reset values. The first edge after release is treated as the IDLE first edge.

## Test plan
- **Steady tick:** one-cycle pulse every 100 cycles, 6 pulses -> first strobe reports 100, 5 strobes total. `locked_out` rises with the 4th strobe (5th pulse).
- **Frequency step:** after lock, period switches to 50 -> the next strobe reports 50 and `locked_out` falls in that cycle. It re-asserts after 4 strobes at 50.
- **Wide pulses:** pulse high 7 cycles, period 20 -> one strobe per pulse, `period_out`=20. Minimum case, alternating high/low each cycle -> `period_out`=2.
- **Overflow:** MAX_PERIOD=64, pulses stop after lock -> `overflow_out`=1 and `locked_out`=0 exactly 64 cycles after the last edge. The next pulse clears overflow with no strobe; the following pulse at period 30 reports 30.
- **Enable/reset:** drop `en_in` mid-period -> IDLE, `period_out` unchanged, no strobe on the next edge. Assert `rst_in` mid-stream -> all outputs 0 asynchronously; the second pulse after release gives the first valid strobe.
- **Edge/saturation coincidence:** MAX_PERIOD=64, pulse exactly 64 cycles after the previous one -> strobe with 64, `overflow_out` stays 0.

Source files
------------

// File: rtl/pulse_period_meter.sv
// Measures clk_in cycles between rising edges of pulse_in, with lock detection
// on a stable period and overflow reporting when pulses stop.
module pulse_period_meter #(
    parameter int unsigned      WIDTH       = 24,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] MAX_PERIOD  = '1,
    parameter int unsigned      LOCK_COUNT  = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] period_out,
    output logic             period_valid_out,
    output logic             locked_out,
    output logic             overflow_out
);
    localparam int unsigned   MW     = 4;
    localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEASURE  = 2'd1,
        OVERFLOW = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   edge_q;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [MW-1:0]          match_q, match_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   locked_q, locked_d;
    logic                   overflow_q, overflow_d;

    // Synchronizer, delay flop and registered rising-edge detect
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q[0] <= pulse_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            dly_q  <= sync_q[SYNC_STAGES-1];
            edge_q <= sync_q[SYNC_STAGES-1] & ~dly_q;
        end
    end

    // State and result registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            match_q    <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            match_q    <= match_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic; a disable overrides any edge seen in the same cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        match_d    = match_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        overflow_d = overflow_q;
        cnt_inc    = (cnt_q == MAX_PERIOD) ? cnt_q : cnt_q + WIDTH'(1);

        if (!en_in) begin
            state_d    = IDLE;
            cnt_d      = '0;
            match_d    = '0;
            locked_d   = 1'b0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (edge_q) begin
                        state_d = MEASURE;
                        cnt_d   = WIDTH'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                MEASURE: begin
                    if (edge_q) begin
                        period_d = cnt_q;
                        valid_d  = 1'b1;
                        cnt_d    = WIDTH'(1);
                        if (cnt_q == period_q) begin
                            match_d = (match_q >= LOCK_N) ? LOCK_N : match_q + MW'(1);
                        end else begin
                            match_d = MW'(1);
                        end
                        locked_d = (match_d >= LOCK_N);
                    end else if (cnt_q == MAX_PERIOD) begin
                        state_d    = OVERFLOW;
                        overflow_d = 1'b1;
                        locked_d   = 1'b0;
                        match_d    = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                OVERFLOW: begin
                    if (edge_q) begin
                        state_d    = MEASURE;
                        overflow_d = 1'b0;
                        cnt_d      = WIDTH'(1);
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign period_out       = period_q;
    assign period_valid_out = valid_q;
    assign locked_out       = locked_q;
    assign overflow_out     = overflow_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Randomized bench for pulse_period_meter: two instances (default and short
// MAX_PERIOD) checked each cycle against a timestamp-based reference model.
module tb_pulse_period_meter;
    localparam int unsigned WIDTH = 24;
    localparam int          S     = 2;
    localparam int          LOCK  = 4;
    localparam int          MAXA  = (1 << WIDTH) - 1;
    localparam int          MAXB  = 64;

    logic             clk_in   = 1'b0;
    logic             rst_in   = 1'b1;
    logic             en_in    = 1'b0;
    logic             pulse_in = 1'b0;
    logic [WIDTH-1:0] per_a, per_b;
    logic             val_a, val_b, lck_a, lck_b, ovf_a, ovf_b;

    always #5 clk_in = ~clk_in;

    pulse_period_meter dut_a (
        .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .pulse_in(pulse_in),
        .period_out(per_a), .period_valid_out(val_a),
        .locked_out(lck_a), .overflow_out(ovf_a)
    );

    pulse_period_meter #(.MAX_PERIOD(24'd64)) dut_b (
        .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .pulse_in(pulse_in),
        .period_out(per_b), .period_valid_out(val_b),
        .locked_out(lck_b), .overflow_out(ovf_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int strobes_a = 0;
    bit chk_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: input edges become events S+1 cycles after first sampling
    logic smp_pulse, smp_en, smp_rst = 1'b0;
    bit   prev_pulse;
    int   ncyc = 0;
    int   evq[$];
    int   mmax [2] = '{MAXA, MAXB};
    bit   m_armed[2], m_ovf[2], m_val[2], m_lck[2];
    int   m_last[2], m_per[2], m_match[2];

    always @(posedge clk_in) begin
        smp_pulse <= pulse_in;
        smp_en    <= en_in;
        smp_rst   <= rst_in;
    end

    task automatic model_reset();
        evq.delete();
        prev_pulse = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_armed[d] = 0; m_ovf[d] = 0; m_val[d] = 0; m_lck[d] = 0;
            m_per[d] = 0; m_match[d] = 0; m_last[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input bit ev, input bit en);
        int el;
        m_val[d] = 1'b0;
        if (!en) begin
            m_armed[d] = 0; m_ovf[d] = 0; m_match[d] = 0; m_lck[d] = 0;
        end else if (ev) begin
            if (!m_armed[d]) begin
                m_armed[d] = 1;
            end else if (m_ovf[d]) begin
                m_ovf[d] = 0;
            end else begin
                el = ncyc - m_last[d];
                m_val[d] = 1'b1;
                if (el == m_per[d]) m_match[d] = (m_match[d] + 1 > LOCK) ? LOCK : m_match[d] + 1;
                else                m_match[d] = 1;
                m_per[d] = el;
                m_lck[d] = (m_match[d] >= LOCK);
            end
            m_last[d] = ncyc;
        end else if (m_armed[d] && !m_ovf[d] && (ncyc - m_last[d] == mmax[d])) begin
            m_ovf[d] = 1; m_lck[d] = 0; m_match[d] = 0;
        end
    endtask

    always @(negedge clk_in) begin
        bit ev;
        if (!rst_in || !smp_rst) begin
            model_reset();
        end else begin
            ncyc++;
            if (smp_pulse && !prev_pulse) evq.push_back(ncyc + S + 1);
            prev_pulse = smp_pulse;
            ev = (evq.size() > 0) && (evq[0] == ncyc);
            if (ev) void'(evq.pop_front());
            for (int d = 0; d < 2; d++) model_step(d, ev, smp_en);
        end
        if (val_a) strobes_a++;
        if (chk_on) begin
            check("a_period",   32'(per_a), 32'(m_per[0]));
            check("a_valid",    32'(val_a), 32'(m_val[0]));
            check("a_locked",   32'(lck_a), 32'(m_lck[0]));
            check("a_overflow", 32'(ovf_a), 32'(m_ovf[0]));
            check("b_period",   32'(per_b), 32'(m_per[1]));
            check("b_valid",    32'(val_b), 32'(m_val[1]));
            check("b_locked",   32'(lck_b), 32'(m_lck[1]));
            check("b_overflow", 32'(ovf_b), 32'(m_ovf[1]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic pulse(input int period, input int width);
        pulse_in = 1'b1;
        cyc(width);
        pulse_in = 1'b0;
        cyc(period - width);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_per_a"}, 32'(per_a), 0);
        check({tag, "_val_a"}, 32'(val_a), 0);
        check({tag, "_lck_a"}, 32'(lck_a), 0);
        check({tag, "_ovf_a"}, 32'(ovf_a), 0);
        check({tag, "_per_b"}, 32'(per_b), 0);
        check({tag, "_ovf_b"}, 32'(ovf_b), 0);
    endtask

    // Asynchronous reset asserted mid-cycle, released just after a clock edge
    task automatic do_reset();
        @(posedge clk_in);
        #3;
        rst_in = 1'b0;
        #1;
        check_all_zero("async_rst");
        cyc(2);
        rst_in = 1'b1;
    endtask

    initial begin
        int p, w, r;
        #2 rst_in = 1'b0;
        en_in = 1'b1;
        cyc(3);
        check_all_zero("reset");
        chk_on = 1'b1;
        rst_in = 1'b1;
        cyc(5);

        // Steady tick
        strobes_a = 0;
        repeat (6) pulse(100, 1);
        check("steady_strobes", 32'(strobes_a), 5);
        check("steady_period", 32'(per_a), 100);
        check("steady_lock", 32'(lck_a), 1);

        // Frequency step
        repeat (5) pulse(50, 1);
        check("step_period", 32'(per_a), 50);
        check("step_relock", 32'(lck_a), 1);

        // Wide pulses, then the minimum period
        repeat (4) pulse(20, 7);
        check("wide_period", 32'(per_a), 20);
        repeat (6) pulse(2, 1);
        check("min_period", 32'(per_a), 2);

        // Overflow on the short-MAX instance
        repeat (5) pulse(30, 1);
        check("pre_ovf_lock", 32'(lck_b), 1);
        cyc(60);
        check("ovf_flag", 32'(ovf_b), 1);
        check("ovf_lock", 32'(lck_b), 0);
        repeat (3) pulse(30, 1);
        check("post_ovf_period", 32'(per_b), 30);

        // Edge coincident with saturation
        repeat (3) pulse(64, 1);
        check("coinc_period", 32'(per_b), 64);
        check("coinc_no_ovf", 32'(ovf_b), 0);

        // Enable dropped mid-period
        repeat (3) pulse(40, 1);
        pulse_in = 1'b1; cyc(1); pulse_in = 1'b0; cyc(15);
        en_in = 1'b0; cyc(10); en_in = 1'b1; cyc(14);
        strobes_a = 0;
        pulse(40, 1);
        check("en_no_strobe", 32'(strobes_a), 0);
        check("en_period_hold", 32'(per_a), 40);
        repeat (2) pulse(40, 1);

        // Reset mid-stream
        repeat (2) pulse(40, 1);
        pulse_in = 1'b1; cyc(1); pulse_in = 1'b0; cyc(10);
        do_reset();
        strobes_a = 0;
        pulse(40, 1);
        check("rst_first_edge", 32'(strobes_a), 0);
        pulse(40, 1);
        check("rst_second_edge", 32'(strobes_a), 1);

        // Randomized traffic
        repeat (150) begin
            p = int'($urandom_range(2, 90));
            w = int'($urandom_range(1, p - 1));
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                en_in = 1'b0;
                cyc(int'($urandom_range(1, 30)));
                en_in = 1'b1;
            end else if (r == 1) begin
                do_reset();
            end else begin
                repeat (int'($urandom_range(1, 4))) pulse(p, w);
            end
        end
        cyc(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
